// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: state/grant encodings and defaults shared by the unified-memory arbiter
package mem_arbiter_pkg;
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2,
    DONE    = 2'd3
  } state_e;
  typedef enum logic {
    GRANT_I = 1'b0,
    GRANT_D = 1'b1
  } grant_e;
  localparam int DEF_MEM_LAT = 4;
  function automatic int cnt_width(input int lat);
    return (lat > 1) ? $clog2(lat) : 1;
  endfunction
endpackage

// File: rtl/mem_arbiter_lat_counter.sv
// arb_lat_counter: loadable down-counter that stops at zero and flags it
module arb_lat_counter #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         zero
);
  logic [W-1:0] cnt_q, cnt_d;
  always_comb cnt_d = load ? load_val : (en && cnt_q != '0) ? cnt_q - W'(1) : cnt_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
  assign zero = (cnt_q == '0);
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter giving fetch and load/store ports
// turns on one shared fixed-latency single-ported memory
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16,
  parameter int MEM_LAT = DEF_MEM_LAT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_rdy,
  output logic [DATA_W-1:0] i_data,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_rdy,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);
  localparam int CW = cnt_width(MEM_LAT);
  state_e            state_q, state_d;
  grant_e            last_grant_q, last_grant_d, gnt;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0] i_data_q, i_data_d, d_rdata_q, d_rdata_d;
  logic              we_q, we_d, serving, cnt_load, cnt_zero;
  assign serving = (state_q == SERVE_I) || (state_q == SERVE_D);
  // on a tie the port that did not win last time goes first
  assign gnt = (d_req && (!i_req || last_grant_q == GRANT_I)) ? GRANT_D : GRANT_I;
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    we_d         = we_q;
    i_data_d     = i_data_q;
    d_rdata_d    = d_rdata_q;
    cnt_load     = 1'b0;
    case (state_q)
      IDLE: if (i_req || d_req) begin
        cnt_load     = 1'b1;
        last_grant_d = gnt;
        state_d      = (gnt == GRANT_D) ? SERVE_D : SERVE_I;
        mem_addr_d   = (gnt == GRANT_D) ? d_addr : i_addr;
        mem_wdata_d  = (gnt == GRANT_D) ? d_wdata : mem_wdata_q;
        we_d         = (gnt == GRANT_D) && d_we;
      end
      SERVE_I: if (cnt_zero) begin
        state_d  = DONE;
        i_data_d = mem_rdata;
      end
      SERVE_D: if (cnt_zero) begin
        state_d   = DONE;
        d_rdata_d = we_q ? d_rdata_q : mem_rdata;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q      <= IDLE;
      last_grant_q <= GRANT_I;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      we_q         <= 1'b0;
      i_data_q     <= '0;
      d_rdata_q    <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      we_q         <= we_d;
      i_data_q     <= i_data_d;
      d_rdata_q    <= d_rdata_d;
    end
  arb_lat_counter #(.W(CW)) u_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (cnt_load),
    .load_val (CW'(MEM_LAT - 1)),
    .en       (serving),
    .zero     (cnt_zero)
  );
  assign mem_en    = serving;
  assign busy      = serving;
  assign mem_we    = we_q && serving;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign i_rdy     = (state_q == DONE) && (last_grant_q == GRANT_I);
  assign d_rdy     = (state_q == DONE) && (last_grant_q == GRANT_D);
  assign i_data    = i_data_q;
  assign d_rdata   = d_rdata_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed stimulus with an expected-transaction scoreboard
// for the fetch / load-store memory arbiter
module tb_mem_arbiter;
  localparam int LAT = 4;
  logic        clk = 1'b0, rst_n = 1'b1;
  logic        i_req, d_req, d_we;
  logic [15:0] i_addr, d_addr, d_wdata;
  logic        i_rdy, d_rdy, mem_en, mem_we, busy;
  logic [15:0] i_data, d_rdata, mem_addr, mem_wdata, mem_rdata;
  logic [15:0] rom [256];
  typedef struct {
    logic        port;
    logic        we;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] rdata;
  } txn_t;
  txn_t        sb[$];
  txn_t        mon_t;
  int          n_tests = 0, n_fail = 0, en_run = 0;
  logic [15:0] exp_i = '0, exp_d = '0;
  logic        prev_rdy = 1'b0;
  mem_arbiter #(.ADDR_W(16), .DATA_W(16), .MEM_LAT(LAT)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req(i_req), .i_addr(i_addr), .i_rdy(i_rdy), .i_data(i_data),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdy(d_rdy), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
  );
  always #5 clk = ~clk;
  assign mem_rdata = rom[mem_addr[7:0]];
  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask
  task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic chkint(input string tag, input int obs, input int exp);
    n_tests++;
    assert (obs == exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic check_zero(input string tag);
    chk1({tag, "_i_rdy"}, i_rdy, 1'b0);
    chk1({tag, "_d_rdy"}, d_rdy, 1'b0);
    chk16({tag, "_i_data"}, i_data, 16'h0);
    chk16({tag, "_d_rdata"}, d_rdata, 16'h0);
    chk1({tag, "_mem_en"}, mem_en, 1'b0);
    chk1({tag, "_mem_we"}, mem_we, 1'b0);
    chk16({tag, "_mem_addr"}, mem_addr, 16'h0);
    chk16({tag, "_mem_wdata"}, mem_wdata, 16'h0);
    chk1({tag, "_busy"}, busy, 1'b0);
  endtask
  task automatic push(input logic port, input logic we, input logic [15:0] addr, input logic [15:0] wdata);
    txn_t t;
    t.port  = port;
    t.we    = we;
    t.addr  = addr;
    t.wdata = wdata;
    t.rdata = we ? 16'h0 : rom[addr[7:0]];
    sb.push_back(t);
  endtask
  task automatic req_i(input logic [15:0] a);
    i_req  = 1'b1;
    i_addr = a;
    push(1'b0, 1'b0, a, 16'h0);
  endtask
  task automatic req_d(input logic we, input logic [15:0] a, input logic [15:0] w);
    d_req   = 1'b1;
    d_we    = we;
    d_addr  = a;
    d_wdata = w;
    push(1'b1, we, a, w);
  endtask
  // requesters drop their req on the cycle they see rdy; latency counted in cycles
  task automatic serve(output int ilat, output int dlat);
    int cyc = 0;
    ilat = -1;
    dlat = -1;
    while ((i_req || d_req) && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (i_rdy && i_req) begin ilat = cyc; i_req = 1'b0; end
      if (d_rdy && d_req) begin dlat = cyc; d_req = 1'b0; end
    end
    chk1("serve_timeout", i_req || d_req, 1'b0);
  endtask
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_i    = '0;
      exp_d    = '0;
      en_run   = 0;
      prev_rdy = 1'b0;
    end else begin
      chk1("busy_vs_en", busy, mem_en);
      if (mem_en) begin
        en_run++;
        if (sb.size() == 0) chk1("en_unexpected", mem_en, 1'b0);
        else begin
          chk16("mem_addr", mem_addr, sb[0].addr);
          chk1("mem_we", mem_we, sb[0].we);
          if (sb[0].we) chk16("mem_wdata", mem_wdata, sb[0].wdata);
        end
      end else chk1("we_idle", mem_we, 1'b0);
      if (i_rdy || d_rdy) begin
        chk1("rdy_pulse", prev_rdy, 1'b0);
        if (sb.size() == 0) chk1("rdy_unexpected", i_rdy | d_rdy, 1'b0);
        else begin
          mon_t = sb.pop_front();
          chk1("rdy_port", d_rdy, mon_t.port);
          chk1("rdy_both", i_rdy & d_rdy, 1'b0);
          chkint("en_cycles", en_run, LAT);
          if (!mon_t.we) begin
            if (mon_t.port) exp_d = mon_t.rdata;
            else exp_i = mon_t.rdata;
          end
        end
        en_run = 0;
      end
      chk16("i_data", i_data, exp_i);
      chk16("d_rdata", d_rdata, exp_d);
      prev_rdy = i_rdy | d_rdy;
    end
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end
  initial begin
    int il, dl, cyc, nrdy;
    i_req = 1'b0; i_addr = '0; d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
    for (int k = 0; k < 256; k++) rom[k] = 16'(k) ^ 16'hC300;
    rom[8'h10] = 16'hA5A5;
    rom[8'h33] = 16'h5A01;
    rom[8'h44] = 16'h1111;
    rom[8'h55] = 16'h2222;
    rom[8'h66] = 16'h3333;
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check_zero("reset");
    #2 rst_n = 1'b1;
    // fetch with the address disturbed mid-service
    @(negedge clk);
    req_i(16'h0010);
    @(negedge clk);
    chk1("fetch_en_c1", mem_en, 1'b1);
    i_addr = 16'hFFFF;
    serve(il, dl);
    chkint("fetch_lat", il + 1, LAT + 1);
    chk16("fetch_addr_hold", mem_addr, 16'h0010);
    // store
    @(negedge clk);
    req_d(1'b1, 16'h0200, 16'h1234);
    serve(il, dl);
    chkint("store_lat", dl, LAT + 1);
    chk16("store_wdata_hold", mem_wdata, 16'h1234);
    chk16("store_addr_hold", mem_addr, 16'h0200);
    // fresh reset, then a tie: D first, I in the first idle cycle after d_rdy
    @(negedge clk);
    #2 rst_n = 1'b0;
    @(negedge clk);
    check_zero("rst2");
    #2 rst_n = 1'b1;
    @(negedge clk);
    req_d(1'b0, 16'h0055, 16'h0);
    req_i(16'h0044);
    serve(il, dl);
    chkint("tie1_d_lat", dl, LAT + 1);
    chkint("tie1_i_lat", il, 2 * (LAT + 2) - 1);
    // lone load moves last grant to D, so the next tie goes to I
    @(negedge clk);
    req_d(1'b0, 16'h0033, 16'h0);
    serve(il, dl);
    chkint("load_lat", dl, LAT + 1);
    @(negedge clk);
    req_i(16'h0066);
    req_d(1'b1, 16'h0077, 16'hBEEF);
    serve(il, dl);
    chkint("tie2_i_lat", il, LAT + 1);
    chkint("tie2_d_lat", dl, 2 * (LAT + 2) - 1);
    // i_req held through the rdy cycle must not start another access
    @(negedge clk);
    req_i(16'h0010);
    cyc = 0;
    while (!i_rdy && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    chkint("hold_lat", cyc, LAT + 1);
    @(negedge clk);
    chk1("hold_no_en", mem_en, 1'b0);
    chk1("hold_no_busy", busy, 1'b0);
    chk1("hold_no_rdy", i_rdy, 1'b0);
    i_req = 1'b0;
    repeat (3) @(negedge clk);
    // reset in service cycle 2 of a load aborts it silently
    req_d(1'b0, 16'h0055, 16'h0);
    repeat (2) @(negedge clk);
    chk1("abort_en_c2", mem_en, 1'b1);
    #2 rst_n = 1'b0;
    #1 check_zero("abort");
    sb.delete();
    d_req = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b1;
    nrdy = 0;
    repeat (8) begin
      @(negedge clk);
      if (d_rdy || i_rdy) nrdy++;
    end
    chkint("abort_no_rdy", nrdy, 0);
    chk1("abort_idle_busy", busy, 1'b0);
    req_i(16'h0044);
    serve(il, dl);
    chkint("post_abort_lat", il, LAT + 1);
    repeat (2) @(negedge clk);
    chkint("sb_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
